// File: rtl/step_sequencer.sv
// step_sequencer: accepts one command (step count, high time, gap) over a
// valid/ready handshake and emits a counted, exactly timed STEP pulse train,
// then strobes DONE (qualified by ABORTED) for one cycle.
module step_sequencer #(
  parameter int CNT_W   = 26,
  parameter int STEPS_W = 16
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [STEPS_W-1:0] CMD_STEPS,
  input  logic [CNT_W-1:0]   CMD_HIGH,
  input  logic [CNT_W-1:0]   CMD_LOW,
  input  logic               ABORT,
  output logic               STEP,
  output logic               BUSY,
  output logic               DONE,
  output logic               ABORTED,
  output logic [STEPS_W-1:0] STEPS_LEFT
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  // Phase limits are stored as (clamped length - 1) so all-ones inputs
  // never need a CNT_W+1 bit comparison.
  logic [CNT_W-1:0]   hi_m1, hi_m1_n, lo_m1, lo_m1_n;
  logic [STEPS_W-1:0] left, left_n;
  logic               pend, pend_n;
  logic               step_q, done_q, aborted_q;
  logic               step_n, done_n, aborted_n;

  // Ready is the only combinational output; ABORT beats CMD_VALID in IDLE.
  assign CMD_READY  = (state == IDLE) & ~ABORT & RSTn;
  assign BUSY       = (state != IDLE);
  assign STEP       = step_q;
  assign DONE       = done_q;
  assign ABORTED    = aborted_q;
  assign STEPS_LEFT = left;

  // State register, phase counter, latched command and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_m1     <= '0;
      lo_m1     <= '0;
      left      <= '0;
      pend      <= 1'b0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hi_m1     <= hi_m1_n;
      lo_m1     <= lo_m1_n;
      left      <= left_n;
      pend      <= pend_n;
      step_q    <= step_n;
      done_q    <= done_n;
      aborted_q <= aborted_n;
    end
  end

  // Next-state logic: phase timing, step accounting and abort handling.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_m1_n = hi_m1;
    lo_m1_n = lo_m1;
    left_n  = left;
    pend_n  = pend;
    case (state)
      IDLE: begin
        pend_n = 1'b0;
        if (CMD_VALID && CMD_READY) begin
          hi_m1_n = (CMD_HIGH == '0) ? '0 : CMD_HIGH - 1'b1;
          lo_m1_n = (CMD_LOW  == '0) ? '0 : CMD_LOW  - 1'b1;
          left_n  = CMD_STEPS;
          cnt_n   = '0;
          state_n = (CMD_STEPS == '0) ? FIN : HIGH;
        end
      end
      HIGH: begin
        // An abort here only takes effect once the pulse is complete.
        if (ABORT) pend_n = 1'b1;
        if (cnt == hi_m1) begin
          cnt_n  = '0;
          left_n = (left != '0) ? left - 1'b1 : '0;
          if (left <= 1 || pend || ABORT) state_n = FIN;
          else                            state_n = LOW;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LOW: begin
        if (ABORT) begin
          pend_n  = 1'b1;
          state_n = FIN;
        end else if (cnt == lo_m1) begin
          cnt_n   = '0;
          state_n = HIGH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      FIN: begin
        pend_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    step_n    = (state_n == HIGH);
    done_n    = (state_n == FIN);
    aborted_n = (state_n == FIN) && pend_n;
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed cases plus random commands checked each
// cycle against a closed-form timeline model of the pulse train.
module tb_step_sequencer;
  localparam int CNT_W = 26, STEPS_W = 16;

  logic CLK = 1'b0, RSTn = 1'b0, CMD_VALID = 1'b0, ABORT = 1'b0;
  logic [STEPS_W-1:0] CMD_STEPS = '0;
  logic [CNT_W-1:0]   CMD_HIGH = '0, CMD_LOW = '0;
  logic CMD_READY, STEP, BUSY, DONE, ABORTED;
  logic [STEPS_W-1:0] STEPS_LEFT;

  int n_chk = 0, n_fail = 0;
  longint last_left = 0;

  step_sequencer #(.CNT_W(CNT_W), .STEPS_W(STEPS_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_STEPS(CMD_STEPS), .CMD_HIGH(CMD_HIGH), .CMD_LOW(CMD_LOW),
    .ABORT(ABORT), .STEP(STEP), .BUSY(BUSY), .DONE(DONE),
    .ABORTED(ABORTED), .STEPS_LEFT(STEPS_LEFT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Random don't-care command fields while the block is busy.
  task automatic scramble();
    CMD_VALID = 1'($urandom_range(0, 1));
    CMD_STEPS = STEPS_W'($urandom_range(0, 9));
    CMD_HIGH  = CNT_W'($urandom_range(0, 9));
    CMD_LOW   = CNT_W'($urandom_range(0, 9));
  endtask

  // Called in an IDLE cycle (after negedge). Issues a command accepted at the
  // end of this cycle (cycle 0), pulses ABORT in cycle ta (0 = never) and
  // optionally pulls RSTn low during cycle rst_t (0 = never).
  task automatic run_cmd(input longint s, input longint h, input longint l,
                         input longint ta, input longint rst_t);
    longint hc, lc, p, fin, k, ph, left_ab, done_ph, exp_left;
    bit ab;
    chk("idle_step", STEP, 0);
    chk("idle_busy", BUSY, 0);
    chk("idle_done", DONE, 0);
    chk("idle_left", STEPS_LEFT, last_left);
    hc = (h == 0) ? 1 : h;
    lc = (l == 0) ? 1 : l;
    p  = hc + lc;
    fin = (s == 0) ? 1 : (s - 1) * p + hc + 1;
    ab = 0; left_ab = 0;
    if (s != 0 && ta >= 1 && ta < fin) begin
      k  = (ta - 1) / p;
      ph = (ta - 1) % p;
      ab = 1;
      left_ab = s - (k + 1);
      fin = (ph < hc) ? k * p + hc + 1 : ta + 1;
    end
    ABORT = 0; CMD_VALID = 1;
    CMD_STEPS = STEPS_W'(s); CMD_HIGH = CNT_W'(h); CMD_LOW = CNT_W'(l);
    #1 chk("ready_idle", CMD_READY, 1);
    for (longint t = 1; t <= fin; t++) begin
      @(negedge CLK);
      if (rst_t != 0 && t == rst_t + 1) begin
        chk("rst_step", STEP, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_left", STEPS_LEFT, 0);
        chk("rst_ready", CMD_READY, 0);
        CMD_VALID = 0; ABORT = 0; RSTn = 1;
        #1 chk("rst_ready_back", CMD_READY, 1);
        last_left = 0;
        return;
      end
      done_ph = (t - 1 >= hc) ? ((t - 1 - hc) / p + 1) : 0;
      if (t < fin) begin
        chk("step", STEP, ((t - 1) % p < hc) ? 1 : 0);
        chk("done", DONE, 0);
        exp_left = s - done_ph;
      end else begin
        chk("step_fin", STEP, 0);
        chk("done_fin", DONE, 1);
        chk("aborted_fin", ABORTED, ab);
        exp_left = ab ? left_ab : 0;
      end
      if (t < fin) chk("aborted", ABORTED, 0);
      chk("busy", BUSY, 1);
      chk("left", STEPS_LEFT, exp_left);
      chk("ready_busy", CMD_READY, 0);
      scramble();
      ABORT = (t == ta);
      if (t == rst_t) RSTn = 0;
    end
    @(negedge CLK);
    last_left = ab ? left_ab : 0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_step", STEP, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_aborted", ABORTED, 0);
    chk("reset_left", STEPS_LEFT, 0);
    chk("reset_ready", CMD_READY, 0);
    RSTn = 1;
    #1;
    run_cmd(3, 4, 2, 0, 0);
    run_cmd(0, 7, 7, 0, 0);
    run_cmd(2, 0, 0, 0, 0);
    run_cmd(5, 4, 2, 2, 0);
    run_cmd(5, 4, 2, 5, 0);
    run_cmd(2, 3, (1 << CNT_W) - 1, 5, 0);
    // ABORT and CMD_VALID together in IDLE: no accept.
    ABORT = 1; CMD_VALID = 1; CMD_STEPS = 3;
    #1 chk("abort_idle_ready", CMD_READY, 0);
    @(negedge CLK);
    chk("abort_idle_busy", BUSY, 0);
    ABORT = 0; CMD_VALID = 0;
    run_cmd(3, 4, 2, 0, 3);
    run_cmd(1, 2, 1, 2, 0);
    for (int i = 0; i < 40; i++) begin
      run_cmd($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 4),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
